// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, almost flags, sticky errors
// and a selectable registered or first-word-fall-through read port.
module sync_fifo_param #(
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned ADDR_WIDTH    = 3,
    parameter int unsigned AFULL_THRESH  = (2 ** ADDR_WIDTH) - 2,
    parameter int unsigned AEMPTY_THRESH = 1,
    parameter bit          FWFT          = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  rd,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic                  fifo_full,
    output logic                  fifo_empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow,
    input  logic                  clr_err
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
    localparam int unsigned PTR_W = ADDR_WIDTH + 1;
    localparam logic [PTR_W-1:0] AFULL_LVL  = PTR_W'(AFULL_THRESH);
    localparam logic [PTR_W-1:0] AEMPTY_LVL = PTR_W'(AEMPTY_THRESH);

    // Configuration sanity: thresholds outside their legal range make a flag meaningless.
    if (ADDR_WIDTH < 1) begin : g_bad_addr
        $error("sync_fifo_param: ADDR_WIDTH must be at least 1");
    end
    if (AFULL_THRESH < 1 || AFULL_THRESH > DEPTH) begin : g_bad_afull
        $error("sync_fifo_param: AFULL_THRESH must be in 1..DEPTH");
    end
    if (AEMPTY_THRESH > DEPTH - 1) begin : g_bad_aempty
        $error("sync_fifo_param: AEMPTY_THRESH must be in 0..DEPTH-1");
    end

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]      r_wptr;
    logic [PTR_W-1:0]      r_rptr;
    logic                  r_overflow;
    logic                  r_underflow;

    logic [PTR_W-1:0]      w_count;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_we;
    logic                  w_re;
    logic [ADDR_WIDTH-1:0] w_waddr;
    logic [ADDR_WIDTH-1:0] w_raddr;

    // Status decode straight from the registered pointers.
    always_comb begin
        w_count = r_wptr - r_rptr;
        w_empty = (r_wptr == r_rptr);
        w_full  = (r_wptr[ADDR_WIDTH] != r_rptr[ADDR_WIDTH]) &&
                  (r_wptr[ADDR_WIDTH-1:0] == r_rptr[ADDR_WIDTH-1:0]);
        w_we    = wr & ~w_full;
        w_re    = rd & ~w_empty;
        w_waddr = r_wptr[ADDR_WIDTH-1:0];
        w_raddr = r_rptr[ADDR_WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_we) r_wptr <= r_wptr + PTR_W'(1);
            if (w_re) r_rptr <= r_rptr + PTR_W'(1);
        end
    end

    // Storage is deliberately left out of reset; stale words are unreachable.
    always_ff @(posedge clk) begin
        if (w_we) r_mem[w_waddr] <= data_in;
    end

    // Sticky errors: a new violation in the clearing cycle keeps the flag set.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_overflow  <= (wr & w_full)  | (r_overflow  & ~clr_err);
            r_underflow <= (rd & w_empty) | (r_underflow & ~clr_err);
        end
    end

    if (FWFT) begin : g_fwft
        // Head word is visible as soon as it is stored; blank while empty.
        always_comb begin
            data_out   = w_empty ? '0 : r_mem[w_raddr];
            data_valid = ~w_empty;
        end
    end else begin : g_reg
        logic [DATA_WIDTH-1:0] r_dout;
        logic                  r_dvalid;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_dout   <= '0;
                r_dvalid <= 1'b0;
            end else begin
                r_dvalid <= w_re;
                if (w_re) r_dout <= r_mem[w_raddr];
            end
        end

        always_comb begin
            data_out   = r_dout;
            data_valid = r_dvalid;
        end
    end

    always_comb begin
        fifo_full    = w_full;
        fifo_empty   = w_empty;
        count        = w_count;
        almost_full  = (w_count >= AFULL_LVL);
        almost_empty = (w_count <= AEMPTY_LVL);
        overflow     = r_overflow;
        underflow    = r_underflow;
    end

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param: registered-read instance plus an FWFT instance.
module tb_sync_fifo_param;

    logic       clk = 1'b0;
    logic       rst;

    logic       wr0, rd0, clr0;
    logic [7:0] din0;
    logic [7:0] dout0;
    logic       dv0, full0, empty0, af0, ae0, ovf0, unf0;
    logic [3:0] cnt0;

    logic       wr1, rd1, clr1;
    logic [7:0] din1;
    logic [7:0] dout1;
    logic       dv1, full1, empty1, af1, ae1, ovf1, unf1;
    logic [3:0] cnt1;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    sync_fifo_param #(.FWFT(1'b0)) u_dut_reg (
        .clk(clk), .rst(rst), .wr(wr0), .data_in(din0), .rd(rd0),
        .data_out(dout0), .data_valid(dv0), .fifo_full(full0), .fifo_empty(empty0),
        .almost_full(af0), .almost_empty(ae0), .count(cnt0),
        .overflow(ovf0), .underflow(unf0), .clr_err(clr0)
    );

    sync_fifo_param #(.FWFT(1'b1)) u_dut_fwft (
        .clk(clk), .rst(rst), .wr(wr1), .data_in(din1), .rd(rd1),
        .data_out(dout1), .data_valid(dv1), .fifo_full(full1), .fifo_empty(empty1),
        .almost_full(af1), .almost_empty(ae1), .count(cnt1),
        .overflow(ovf1), .underflow(unf1), .clr_err(clr1)
    );

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] d;
        rst = 1'b0;
        wr0 = 0; rd0 = 0; clr0 = 0; din0 = 0;
        wr1 = 0; rd1 = 0; clr1 = 0; din1 = 0;
        #3;
        check_val("rst_count", 32'(cnt0), 0);
        check_val("rst_empty", 32'(empty0), 1);
        check_val("rst_full", 32'(full0), 0);
        check_val("rst_ae", 32'(ae0), 1);
        check_val("rst_af", 32'(af0), 0);
        check_val("rst_dv", 32'(dv0), 0);
        check_val("rst_dout", 32'(dout0), 0);
        check_val("rst_ovf", 32'(ovf0), 0);
        check_val("rst_unf", 32'(unf0), 0);
        check_val("rst_fwft_dv", 32'(dv1), 0);
        tick();
        rst = 1'b1;

        // Fill 0x11..0x88, then drain in order.
        for (int i = 0; i < 8; i++) begin
            wr0 = 1; din0 = 8'((i + 1) * 8'h11);
            tick();
            check_val("fill_count", 32'(cnt0), 32'(i + 1));
            check_val("fill_af", 32'(af0), (i + 1 >= 6) ? 1 : 0);
            check_val("fill_full", 32'(full0), (i + 1 == 8) ? 1 : 0);
        end
        wr0 = 0;
        for (int i = 0; i < 8; i++) begin
            rd0 = 1;
            tick();
            check_val("drain_dout", 32'(dout0), 32'((i + 1) * 8'h11));
            check_val("drain_dv", 32'(dv0), 1);
            check_val("drain_count", 32'(cnt0), 32'(7 - i));
        end
        rd0 = 0;
        tick();
        check_val("idle_dv", 32'(dv0), 0);
        check_val("idle_dout_hold", 32'(dout0), 32'h88);
        check_val("idle_empty", 32'(empty0), 1);
        check_val("idle_ae", 32'(ae0), 1);

        // Overflow on a full FIFO; the rejected word must never come out.
        for (int i = 0; i < 8; i++) begin
            wr0 = 1; din0 = 8'(8'h20 + i);
            tick();
        end
        din0 = 8'hEE;
        tick();
        wr0 = 0;
        check_val("ovf_set", 32'(ovf0), 1);
        check_val("ovf_count", 32'(cnt0), 8);
        clr0 = 1;
        tick();
        clr0 = 0;
        check_val("ovf_clr", 32'(ovf0), 0);
        for (int i = 0; i < 8; i++) begin
            rd0 = 1;
            tick();
            check_val("ovf_drain", 32'(dout0), 32'(8'h20 + i));
        end
        rd0 = 0;
        tick();

        // Underflow on an empty FIFO.
        rd0 = 1;
        tick();
        rd0 = 0;
        check_val("unf_set", 32'(unf0), 1);
        check_val("unf_dv", 32'(dv0), 0);
        check_val("unf_dout_hold", 32'(dout0), 32'h27);
        clr0 = 1;
        tick();
        clr0 = 0;
        check_val("unf_clr", 32'(unf0), 0);

        // Simultaneous wr/rd at empty and at full.
        wr0 = 1; rd0 = 1; din0 = 8'h5A;
        tick();
        rd0 = 0;
        check_val("er_count", 32'(cnt0), 1);
        check_val("er_unf", 32'(unf0), 1);
        check_val("er_dv", 32'(dv0), 0);
        for (int i = 0; i < 7; i++) begin
            din0 = 8'(8'h60 + i);
            tick();
        end
        check_val("fr_full", 32'(full0), 1);
        rd0 = 1; din0 = 8'h77;
        tick();
        wr0 = 0; rd0 = 0;
        check_val("fr_count", 32'(cnt0), 7);
        check_val("fr_ovf", 32'(ovf0), 1);
        check_val("fr_dout", 32'(dout0), 32'h5A);
        check_val("fr_dv", 32'(dv0), 1);
        for (int i = 0; i < 7; i++) begin
            rd0 = 1;
            tick();
            check_val("fr_drain", 32'(dout0), 32'(8'h60 + i));
        end
        rd0 = 0;

        // Write/read pairs carry both pointers around their range twice.
        for (int i = 0; i < 32; i++) begin
            d = 8'(8'hC3 ^ (i * 7));
            wr0 = 1; din0 = d;
            tick();
            wr0 = 0; rd0 = 1;
            tick();
            rd0 = 0;
            check_val("wrap_dout", 32'(dout0), 32'(d));
        end
        check_val("wrap_empty", 32'(empty0), 1);

        // FWFT: head visible without a read, pop exposes the next word.
        wr1 = 1; din1 = 8'hA1;
        tick();
        check_val("fwft_dv_first", 32'(dv1), 1);
        check_val("fwft_head", 32'(dout1), 32'hA1);
        din1 = 8'hB2;
        tick();
        wr1 = 0;
        check_val("fwft_head_hold", 32'(dout1), 32'hA1);
        rd1 = 1;
        tick();
        check_val("fwft_pop1", 32'(dout1), 32'hB2);
        check_val("fwft_pop1_dv", 32'(dv1), 1);
        tick();
        rd1 = 0;
        check_val("fwft_pop2_dv", 32'(dv1), 0);
        check_val("fwft_empty", 32'(empty1), 1);

        // Asynchronous reset in the middle of a burst at count 5.
        for (int i = 0; i < 5; i++) begin
            wr0 = 1; din0 = 8'(8'h90 + i);
            wr1 = 1; din1 = 8'(8'h90 + i);
            tick();
        end
        wr0 = 0; wr1 = 0;
        check_val("mid_count", 32'(cnt0), 5);
        check_val("mid_fwft_head", 32'(dout1), 32'h90);
        #2;
        rst = 1'b0;
        #1;
        check_val("arst_count", 32'(cnt0), 0);
        check_val("arst_empty", 32'(empty0), 1);
        check_val("arst_ae", 32'(ae0), 1);
        check_val("arst_af", 32'(af0), 0);
        check_val("arst_full", 32'(full0), 0);
        check_val("arst_dout", 32'(dout0), 0);
        check_val("arst_dv", 32'(dv0), 0);
        check_val("arst_ovf", 32'(ovf0), 0);
        check_val("arst_unf", 32'(unf0), 0);
        check_val("arst_fwft_count", 32'(cnt1), 0);
        check_val("arst_fwft_dv", 32'(dv1), 0);
        check_val("arst_fwft_dout", 32'(dout1), 0);
        tick();
        rst = 1'b1;

        // First accepted write after reset release.
        wr0 = 1; din0 = 8'h3C;
        tick();
        wr0 = 0; rd0 = 1;
        tick();
        rd0 = 0;
        check_val("post_rst_dout", 32'(dout0), 32'h3C);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
